mem_access_stage: RTL

MIPS MEM stage: consumes the EX/MEM pipeline register outputs, performs the data-memory access over a req/ack bus, and registers the result into the MEM/WB boundary. Byte, halfword and word loads/stores are supported, with sign/zero extension and alignment checking. The block stalls the upstream pipeline while a memory access is outstanding and inserts a bubble toward write-back.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mem_lane_align.sv | 53 +++++
 rtl/mem_access_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg : shared encodings for the MIPS MEM stage                   |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
package mips_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_RSVD = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_lane_align : byte enables, store replication, load extend, align |
// | Rev 1.0        : initial release                                     |
// +----------------------------------------------------------------------+
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;

    always_comb begin
        w_rd_byte  = rdata_i[8*addr_lo_i +: 8];
        w_rd_half  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        be_o       = 4'b0000;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
        misalign_o = 1'b0;
        case (size_i)
            MEM_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{signed_i & w_rd_byte[7]}}, w_rd_byte};
            end
            MEM_HALF: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = {{16{signed_i & w_rd_half[15]}}, w_rd_half};
                misalign_o = addr_lo_i[0];
            end
            MEM_WORD: begin
                be_o       = 4'b1111;
                misalign_o = |addr_lo_i;
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_stage : MIPS MEM stage with req/ack data-memory access    |
// | Rev 1.0          : initial release                                   |
// +----------------------------------------------------------------------+
module mem_access_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ValidIn,
    input  logic        RegWriteIn,
    input  logic        MemtoRegIn,
    input  logic        MemWriteIn,
    input  logic        MemReadIn,
    input  logic [1:0]  MemSizeIn,
    input  logic        MemSignedIn,
    input  logic [31:0] ALUResultIn,
    input  logic [4:0]  WriteRegIn,
    input  logic [31:0] WriteDataIn,
    output logic        Stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        ValidOut,
    output logic        RegWriteOut,
    output logic        MemtoRegOut,
    output logic [31:0] ALUResultOut,
    output logic [31:0] ReadDataOut,
    output logic [4:0]  WriteRegOut,
    output logic        AddrErr
);

    mem_state_e  state_q;
    logic        regwrite_q;
    logic        memtoreg_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] alu_q;
    logic [4:0]  wreg_q;

    logic        w_in_wait;
    logic        w_is_mem;
    logic        w_start;
    logic        w_err;
    logic [1:0]  w_size;
    logic        w_signed;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic        w_misalign;
    logic [31:0] read_data_d;

    // While waiting, the lane logic works on the latched access so the
    // load extraction matches the request that is actually on the bus.
    assign w_in_wait = (state_q == WAIT);
    assign w_size    = w_in_wait ? size_q      : MemSizeIn;
    assign w_signed  = w_in_wait ? signed_q    : MemSignedIn;
    assign w_addr_lo = w_in_wait ? alu_q[1:0]  : ALUResultIn[1:0];

    mem_lane_align u_align (
        .size_i     (w_size),
        .signed_i   (w_signed),
        .addr_lo_i  (w_addr_lo),
        .wdata_i    (WriteDataIn),
        .rdata_i    (mem_rdata),
        .be_o       (w_be),
        .wdata_o    (w_wdata),
        .rdata_o    (w_rdata),
        .misalign_o (w_misalign)
    );

    assign w_is_mem    = ValidIn & (MemReadIn | MemWriteIn);
    assign w_start     = w_is_mem & ~w_misalign;
    assign w_err       = w_is_mem & w_misalign;
    assign read_data_d = mem_we ? 32'h0 : w_rdata;
    assign Stall       = rst_n & (w_in_wait ? ~mem_ack : w_start);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_be       <= 4'b0000;
            mem_wdata    <= 32'h0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            size_q       <= MEM_BYTE;
            signed_q     <= 1'b0;
            alu_q        <= 32'h0;
            wreg_q       <= 5'd0;
            ValidOut     <= 1'b0;
            RegWriteOut  <= 1'b0;
            MemtoRegOut  <= 1'b0;
            ALUResultOut <= 32'h0;
            ReadDataOut  <= 32'h0;
            WriteRegOut  <= 5'd0;
            AddrErr      <= 1'b0;
        end else begin
            // Bubble toward write-back unless a result retires below.
            ValidOut     <= 1'b0;
            RegWriteOut  <= 1'b0;
            MemtoRegOut  <= 1'b0;
            ALUResultOut <= 32'h0;
            ReadDataOut  <= 32'h0;
            WriteRegOut  <= 5'd0;
            AddrErr      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_start) begin
                        state_q    <= WAIT;
                        mem_req    <= 1'b1;
                        mem_we     <= MemWriteIn;
                        mem_addr   <= {ALUResultIn[31:2], 2'b00};
                        mem_be     <= w_be;
                        mem_wdata  <= w_wdata;
                        regwrite_q <= RegWriteIn;
                        memtoreg_q <= MemtoRegIn;
                        size_q     <= MemSizeIn;
                        signed_q   <= MemSignedIn;
                        alu_q      <= ALUResultIn;
                        wreg_q     <= WriteRegIn;
                    end else if (ValidIn) begin
                        ValidOut     <= 1'b1;
                        RegWriteOut  <= RegWriteIn & ~w_err;
                        MemtoRegOut  <= MemtoRegIn;
                        ALUResultOut <= ALUResultIn;
                        WriteRegOut  <= WriteRegIn;
                        AddrErr      <= w_err;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state_q      <= IDLE;
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        ValidOut     <= 1'b1;
                        RegWriteOut  <= regwrite_q;
                        MemtoRegOut  <= memtoreg_q;
                        ALUResultOut <= alu_q;
                        ReadDataOut  <= read_data_d;
                        WriteRegOut  <= wreg_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
